// File: rtl/cv_arb_pkg.sv
// cv_arb_pkg: shared types and widths for the two-master arbiter.
package cv_arb_pkg;
  localparam int ADDR_W_DEF = 40;
  localparam int CMD_W = 3;
  localparam int DATA_W = 8;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
endpackage

// File: rtl/cv_arb_tmo.sv
// cv_arb_tmo: BUSY-cycle counter flagging expiry on the TMO_CYC-th cycle.
module cv_arb_tmo #(
  parameter int TMO_CYC = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  output logic expired
);
  logic [7:0] cnt;
  assign expired = enable && (cnt == 8'(TMO_CYC - 1));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clear) cnt <= '0;
    else if (enable && !expired) cnt <= cnt + 8'd1;
endmodule

// File: rtl/cv_arb_40b.sv
// cv_arb_40b: round-robin arbiter of two masters onto one decoder port.
// Define CV_ARB_TIMEOUT_EN to abort unacknowledged transfers after TMO_CYC cycles.
module cv_arb_40b
  import cv_arb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int TMO_CYC = 255
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              M0_S_EX_REQ,
  input  logic [ADDR_W-1:0] M0_S_ADDR,
  input  logic [CMD_W-1:0]  M0_S_CMD,
  input  logic [DATA_W-1:0] M0_S_D_WR,
  output logic              M0_S_EX_ACK,
  output logic [DATA_W-1:0] M0_S_D_RD,
  input  logic              M1_S_EX_REQ,
  input  logic [ADDR_W-1:0] M1_S_ADDR,
  input  logic [CMD_W-1:0]  M1_S_CMD,
  input  logic [DATA_W-1:0] M1_S_D_WR,
  output logic              M1_S_EX_ACK,
  output logic [DATA_W-1:0] M1_S_D_RD,
  output logic              T_S_EX_REQ,
  output logic [ADDR_W-1:0] T_S_ADDR,
  output logic [CMD_W-1:0]  T_S_CMD,
  output logic [DATA_W-1:0] T_S_D_WR,
  input  logic              T_S_EX_ACK,
  input  logic [DATA_W-1:0] T_S_D_RD,
  output logic [1:0]        GNT,
  output logic              ERR
);
  state_t state;
  logic last;
  logic tmo;
  logic pick1;
  logic [DATA_W-1:0] rsp;
  // last=1 means master 1 was served most recently, so master 0 wins a tie
  assign pick1 = M1_S_EX_REQ && (!M0_S_EX_REQ || !last);
  assign rsp = T_S_EX_ACK ? T_S_D_RD : 8'hFF;
`ifdef CV_ARB_TIMEOUT_EN
  cv_arb_tmo #(.TMO_CYC(TMO_CYC)) u_tmo (
    .clk(CLK),
    .rst_n(RST_N),
    .enable(state == BUSY),
    .clear(state != BUSY),
    .expired(tmo)
  );
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) ERR <= 1'b0;
    else if (state == BUSY && !T_S_EX_ACK && tmo) ERR <= 1'b1;
`else
  assign tmo = 1'b0;
  assign ERR = 1'b0;
`endif
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
      last <= 1'b1;
      GNT <= '0;
      T_S_EX_REQ <= 1'b0;
      T_S_ADDR <= '0;
      T_S_CMD <= '0;
      T_S_D_WR <= '0;
      M0_S_EX_ACK <= 1'b0;
      M1_S_EX_ACK <= 1'b0;
      M0_S_D_RD <= '0;
      M1_S_D_RD <= '0;
    end else begin
      case (state)
        IDLE: if (M0_S_EX_REQ || M1_S_EX_REQ) begin
          GNT <= pick1 ? 2'b10 : 2'b01;
          T_S_ADDR <= pick1 ? M1_S_ADDR : M0_S_ADDR;
          T_S_CMD <= pick1 ? M1_S_CMD : M0_S_CMD;
          T_S_D_WR <= pick1 ? M1_S_D_WR : M0_S_D_WR;
          T_S_EX_REQ <= 1'b1;
          state <= BUSY;
        end
        BUSY: if (T_S_EX_ACK || tmo) begin
          T_S_EX_REQ <= 1'b0;
          M0_S_EX_ACK <= GNT[0];
          M1_S_EX_ACK <= GNT[1];
          M0_S_D_RD <= GNT[0] ? rsp : '0;
          M1_S_D_RD <= GNT[1] ? rsp : '0;
          state <= RESP;
        end
        RESP: begin
          M0_S_EX_ACK <= 1'b0;
          M1_S_EX_ACK <= 1'b0;
          M0_S_D_RD <= '0;
          M1_S_D_RD <= '0;
          last <= GNT[1];
          GNT <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/cv_arb_40b.md
CV_ARB_40B -- requirements
Module: cv_arb_40b

Interface
REQ-001 SHALL have parameter ADDR_W, default 40, meaning the address width of all ports.
REQ-002 SHALL have parameter TMO_CYC, default 255, meaning the maximum number of cycles to wait for T_S_EX_ACK (range 1..255).
REQ-003 SHALL have one clock and reset port pair: CLK (input, 1, rising-edge clock) and RST_N (input, 1), with reset asynchronous and active-low.
REQ-004 SHALL have M0_S_EX_REQ  in  1  request from master 0 (command processor).
REQ-005 SHALL have M0_S_ADDR  in  ADDR_W, M0_S_CMD  in  3, and M0_S_D_WR  in  8 for master 0 address, command and write data.
REQ-006 SHALL have M0_S_EX_ACK  out  1  and M0_S_D_RD  out  8 for master 0 completion strobe and read data.
REQ-007 SHALL have M1_S_* ports identical to REQ-004..006 for master 1 (loader).
REQ-008 SHALL have T_S_EX_REQ  out  1, T_S_ADDR  out  ADDR_W, T_S_CMD  out  3, and T_S_D_WR  out  8 toward the shared decoder target port.
REQ-009 SHALL have T_S_EX_ACK  in  1  and T_S_D_RD  in  8 from the decoder.
REQ-010 SHALL have GNT  out  2  one-hot current owner, and ERR  out  1  sticky timeout flag.

Function
REQ-011 SHALL implement FSM states IDLE, BUSY, RESP; reset state IDLE.
REQ-012 SHALL, in IDLE with at least one Mx_S_EX_REQ high, grant one master, register its ADDR/CMD/D_WR onto T_S_*, set T_S_EX_REQ=1 and GNT, and go to BUSY: 1 cycle from REQ sample to T_S_EX_REQ.
REQ-013 SHALL, when both request in the same IDLE cycle, grant the master not served last (round-robin); after reset, master 0 wins first.
REQ-014 SHALL hold T_S_* stable throughout BUSY, independent of master inputs; a master dropping REQ in BUSY does not abort the transfer.
REQ-015 SHALL, in BUSY with T_S_EX_ACK=1 sampled, capture T_S_D_RD, clear T_S_EX_REQ, and go to RESP.
REQ-016 SHALL, in RESP, drive the granted Mx_S_EX_ACK=1 for exactly one cycle with Mx_S_D_RD = captured data, update the last-served pointer, clear GNT, and return to IDLE.
REQ-017 SHALL keep the non-granted master's ACK=0 and D_RD=8'h00 at all times, and the granted master's D_RD=8'h00 outside RESP.
REQ-018 SHALL insert no back-to-back grant: min 1 IDLE cycle between transfers, so each master drops REQ after its ACK before re-arbitration.
REQ-019 SHALL, when T_S_EX_ACK is high in IDLE or RESP, ignore it.

Reset
REQ-020 SHALL, while RST_N=0 (asynchronous), force all outputs to 0, state to IDLE, last-served to master 1, ERR to 0, and the timeout counter to 0.
REQ-021 SHALL, on reset mid-transfer, drop T_S_EX_REQ immediately without issuing an ACK to the master.

Configuration
REQ-022 SHALL, with CV_ARB_TIMEOUT_EN defined, count BUSY cycles; if the count reaches TMO_CYC without ACK, clear T_S_EX_REQ, go to RESP with D_RD=8'hFF, and set ERR (cleared only by reset).
REQ-023 SHALL, without CV_ARB_TIMEOUT_EN, keep BUSY indefinitely until ACK and tie ERR to 0, with no counter logic present.

Structure
REQ-024 SHALL take the state enum, ADDR_W default, CMD width (3) and data width (8) from package cv_arb_pkg.
REQ-025 SHALL place the timeout counter in sub-module cv_arb_tmo (enable, clear, expired), instantiated only under CV_ARB_TIMEOUT_EN.

Verification
REQ-026 SHALL verify that M0 read ADDR=40'h2F7539_98EE, with the slave acking 3 cycles after T_S_EX_REQ and D_RD=8'hA5, results in M0_S_EX_ACK one cycle later, one cycle wide, with M0_S_D_RD=8'hA5.
REQ-027 SHALL verify that M0 and M1 requesting in the same cycle after reset produces grant order M0, M1, M0, M1 over 4 transfers, with GNT matching each.
REQ-028 SHALL verify that changing M1 ADDR/D_WR during BUSY leaves T_S_ADDR/T_S_D_WR at their granted values until RESP.
REQ-029 SHALL verify that, with CV_ARB_TIMEOUT_EN and TMO_CYC=4 and the slave never acking, the master receives ACK with D_RD=8'hFF and ERR=1 stays high until RST_N=0.
REQ-030 SHALL verify that RST_N asserted in BUSY causes T_S_EX_REQ, GNT, and both ACKs to go to 0 without a clock edge, and that the first post-reset grant goes to M0.
